mat_loader: RTL and testbench

- Upstream stage of the systolic MAC array: fetches the B vector and the 8 A rows from the 64-bit memory wrapper over an Avalon-MM read interface.
- Unpacks each 64-bit word into 8-bit elements and writes them into the per-row A FIFOs and the B FIFO.
- Replaces the ad-hoc buffer-fill and FIFO-fill logic in the top level; the top-level FSM starts it and waits for done before starting calculation.

---
 rtl/mat_loader.sv | 175 +++++++++++++++++
 tb/tb_mat_loader.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mat_loader
//  Description : Fetches the B vector and the A rows over Avalon-MM and
//                unpacks each word MSB-first into the B / per-row A FIFOs.
//  Revision    : 1.0 - initial release
// ============================================================================
module mat_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_W     = 64,
    parameter int ROWS       = 8,
    parameter int B_ADDR     = 0,
    parameter int A_BASE     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           avm_address,
    output logic                  avm_read,
    input  logic [WORD_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    input  logic                  avm_waitrequest,
    output logic [DATA_WIDTH-1:0] a_data,
    output logic [ROWS-1:0]       a_wrreq,
    input  logic [ROWS-1:0]       a_wrfull,
    output logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_wrreq,
    input  logic                  b_wrfull
);

    localparam int c_ELEMS  = WORD_W / DATA_WIDTH;
    localparam int c_BYTE_W = (c_ELEMS > 1) ? $clog2(c_ELEMS) : 1;
    localparam int c_IDX_W  = $clog2(ROWS + 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_REQ    = 3'd1;
    localparam logic [2:0] c_RESP   = 3'd2;
    localparam logic [2:0] c_UNPACK = 3'd3;
    localparam logic [2:0] c_FIN    = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_BYTE_W-1:0]   r_byte;
    logic [WORD_W-1:0]     r_word;
    logic [31:0]           r_addr;
    logic [DATA_WIDTH-1:0] r_a_data;
    logic [DATA_WIDTH-1:0] r_b_data;
    logic [ROWS-1:0]       r_a_wrreq;
    logic                  r_b_wrreq;

    // Bit 0 selects the B FIFO, bit r+1 selects A FIFO r.
    logic [ROWS:0]         w_sel;
    logic                  w_target_full;
    logic                  w_issue;
    logic                  w_last_elem;
    logic                  w_last_word;
    logic [DATA_WIDTH-1:0] w_elem;

    assign w_sel         = (ROWS + 1)'(1) << r_idx;
    assign w_target_full = |({a_wrfull, b_wrfull} & w_sel);
    assign w_issue       = (r_state == c_UNPACK) && !w_target_full;
    assign w_last_elem   = (r_byte == c_BYTE_W'(c_ELEMS - 1));
    assign w_last_word   = (r_idx == c_IDX_W'(ROWS));
    // The word register shifts left per issued element, so the head is always the next one.
    assign w_elem        = r_word[WORD_W-1 -: DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        avm_read     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next_state = c_REQ;
                end
            end
            c_REQ: begin
                busy     = 1'b1;
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    w_next_state = c_RESP;
                end
            end
            c_RESP: begin
                busy = 1'b1;
                if (avm_readdatavalid) begin
                    w_next_state = c_UNPACK;
                end
            end
            c_UNPACK: begin
                busy = 1'b1;
                if (w_issue && w_last_elem) begin
                    w_next_state = w_last_word ? c_FIN : c_REQ;
                end
            end
            c_FIN: begin
                done         = 1'b1;
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_byte    <= '0;
            r_word    <= '0;
            r_addr    <= '0;
            r_a_data  <= '0;
            r_b_data  <= '0;
            r_a_wrreq <= '0;
            r_b_wrreq <= 1'b0;
        end else begin
            r_a_wrreq <= '0;
            r_b_wrreq <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_idx  <= '0;
                        r_addr <= 32'(B_ADDR);
                    end
                end
                c_RESP: begin
                    if (avm_readdatavalid) begin
                        r_word <= avm_readdata;
                        r_byte <= '0;
                    end
                end
                c_UNPACK: begin
                    if (w_issue) begin
                        if (w_sel[0]) begin
                            r_b_data <= w_elem;
                        end else begin
                            r_a_data <= w_elem;
                        end
                        r_a_wrreq <= w_sel[ROWS:1];
                        r_b_wrreq <= w_sel[0];
                        r_word    <= r_word << DATA_WIDTH;
                        r_byte    <= r_byte + 1'b1;
                        if (w_last_elem && !w_last_word) begin
                            r_idx  <= r_idx + 1'b1;
                            // Next word index is r_idx+1, i.e. A row r_idx.
                            r_addr <= 32'(A_BASE) + 32'(r_idx);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign avm_address = r_addr;
    assign a_data      = r_a_data;
    assign b_data      = r_b_data;
    assign a_wrreq     = r_a_wrreq;
    assign b_wrreq     = r_b_wrreq;

endmodule
`default_nettype wire

// File: tb/tb_mat_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mat_loader
//  Description : Self-checking bench for mat_loader with a memory/FIFO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_loader;

    localparam int DW     = 8;
    localparam int WW     = 64;
    localparam int ROWS   = 8;
    localparam int B_ADDR = 0;
    localparam int A_BASE = 2;
    localparam int NB     = WW / DW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            busy;
    logic            done;
    logic [31:0]     avm_address;
    logic            avm_read;
    logic [WW-1:0]   avm_readdata;
    logic            avm_readdatavalid;
    logic            avm_waitrequest;
    logic [DW-1:0]   a_data;
    logic [ROWS-1:0] a_wrreq;
    logic [ROWS-1:0] a_wrfull;
    logic [DW-1:0]   b_data;
    logic            b_wrreq;
    logic            b_wrfull;

    mat_loader #(
        .DATA_WIDTH(DW), .WORD_W(WW), .ROWS(ROWS), .B_ADDR(B_ADDR), .A_BASE(A_BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
        .a_data(a_data), .a_wrreq(a_wrreq), .a_wrfull(a_wrfull),
        .b_data(b_data), .b_wrreq(b_wrreq), .b_wrfull(b_wrfull)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [WW-1:0] mem [0:15];
    int            got [$];      // (fifo << 8) | byte, fifo 8 is B
    int            exp_q [$];
    logic [31:0]   acc_addr [$];
    int            cnt_fifo [0:8];
    int            done_cnt;
    int            proto_viol;
    int            accepted;
    int            ws_first    = 0;
    bit            rand_ws     = 0;
    bit            rand_lat    = 0;
    bit            rand_full   = 0;
    int            full3_trig  = 0;
    int            inject_b_at = 0;
    bit            inject_now  = 0;

    // Memory slave, FIFO full driver and write monitor, all on the falling edge.
    initial begin : bus_model
        bit            pend;
        int            lat_cnt;
        logic [WW-1:0] pend_data;
        bit            in_wait;
        int            ws_left;
        int            full3_left;
        logic [31:0]   held;
        pend = 0; lat_cnt = 0; pend_data = '0; in_wait = 0; ws_left = 0; held = '0; full3_left = 0;
        avm_readdata = '0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
        a_wrfull = '0; b_wrfull = 1'b0;
        forever begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            if (!rst_n) begin
                pend = 0; in_wait = 0; full3_left = 0;
                avm_waitrequest = 1'b0; a_wrfull = '0; b_wrfull = 1'b0;
            end else begin
                if ($countones({a_wrreq, b_wrreq}) > 1) proto_viol++;
                if ((a_wrreq & a_wrfull) != '0 || (b_wrreq && b_wrfull)) proto_viol++;
                if (b_wrreq) begin
                    got.push_back((8 << 8) | int'(b_data));
                    cnt_fifo[8]++;
                end
                for (int r = 0; r < ROWS; r++) begin
                    if (a_wrreq[r]) begin
                        got.push_back((r << 8) | int'(a_data));
                        cnt_fifo[r]++;
                    end
                end
                if (done) done_cnt++;
                if (avm_read && pend) proto_viol++;
                if (pend) begin
                    if (lat_cnt == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = pend_data;
                        pend              = 0;
                    end else begin
                        lat_cnt--;
                    end
                end
                if (inject_now) begin
                    inject_now        = 0;
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = 64'hA5A5_5A5A_C3C3_3C3C;
                end
                if (inject_b_at > 0 && cnt_fifo[8] == inject_b_at) begin
                    inject_b_at       = 0;
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = 64'hDEAD_BEEF_0BAD_F00D;
                end
                avm_waitrequest = 1'b0;
                if (avm_read) begin
                    if (!in_wait) begin
                        in_wait  = 1;
                        held     = avm_address;
                        ws_left  = rand_ws ? int'($urandom_range(0, 3)) : ws_first;
                        ws_first = 0;
                    end else if (avm_address !== held) begin
                        proto_viol++;
                    end
                    if (ws_left > 0) begin
                        avm_waitrequest = 1'b1;
                        ws_left--;
                    end else begin
                        accepted++;
                        acc_addr.push_back(avm_address);
                        pend      = 1;
                        lat_cnt   = rand_lat ? int'($urandom_range(0, 2)) : 0;
                        pend_data = mem[avm_address[3:0]];
                        in_wait   = 0;
                    end
                end else if (in_wait) begin
                    proto_viol++;
                end
                a_wrfull = '0;
                b_wrfull = 1'b0;
                if (rand_full) begin
                    a_wrfull = ROWS'($urandom) & ROWS'($urandom);
                    b_wrfull = ($urandom_range(0, 3) == 0);
                end else if (full3_left > 0) begin
                    a_wrfull = 8'h08;
                    full3_left--;
                end else if (full3_trig > 0 && cnt_fifo[3] == full3_trig) begin
                    full3_trig = 0;
                    a_wrfull   = 8'h08;
                    full3_left = 3;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_records();
        got.delete();
        acc_addr.delete();
        for (int i = 0; i <= 8; i++) cnt_fifo[i] = 0;
        done_cnt = 0; proto_viol = 0; accepted = 0;
    endtask

    function automatic void load_basic_mem();
        for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
        mem[B_ADDR] = 64'h0102030405060708;
        for (int r = 0; r < ROWS; r++)
            mem[A_BASE + r] = 64'h1112131415161718 + 64'(r) * 64'h1010101010101010;
    endfunction

    // Reference: B word then rows 0..ROWS-1, each split MSB-first into bytes.
    function automatic void build_expected();
        logic [WW-1:0] w;
        int            fifo;
        exp_q.delete();
        for (int k = 0; k <= ROWS; k++) begin
            w    = (k == 0) ? mem[B_ADDR] : mem[A_BASE + k - 1];
            fifo = (k == 0) ? 8 : k - 1;
            for (int j = 0; j < NB; j++)
                exp_q.push_back((fifo << 8) | int'((w >> (WW - DW * (j + 1))) & 64'hFF));
        end
    endfunction

    task automatic run_load(input int restart_at, output int cyc);
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == restart_at) start = 1'b1;
            if (done) break;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL load_timeout: done=%b after %0d cycles, required 1", done, cyc);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, avm_read, b_wrreq} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/read/b_wrreq=%b, required 0000", {busy, done, avm_read, b_wrreq});
        end
        n_checks++;
        if (a_wrreq !== '0) begin
            n_fail++;
            $display("FAIL reset_a_wrreq: got %h, required 00", a_wrreq);
        end
        n_checks++;
        if (avm_address !== 32'd0 || a_data !== '0 || b_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h a_data=%h b_data=%h, required 0", avm_address, a_data, b_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_basic();
        int cyc, bad;
        load_basic_mem(); build_expected(); clear_records();
        run_load(0, cyc);
        n_checks++;
        if (cyc != 91) begin n_fail++; $display("FAIL basic_done_cycle: got %0d, required 91", cyc); end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d, required 1", done_cnt); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b, required 0", busy); end
        bad = (got.size() != exp_q.size()) ? 1 : 0;
        foreach (exp_q[i]) if (i >= got.size() || got[i] != exp_q[i]) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL basic_data: %0d wrong of %0d writes, required 0 wrong of 72", bad, got.size()); end
        bad = (acc_addr.size() != ROWS + 1) ? 1 : 0;
        for (int i = 0; i < acc_addr.size() && i <= ROWS; i++)
            if (acc_addr[i] !== ((i == 0) ? 32'(B_ADDR) : 32'(A_BASE + i - 1))) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL basic_addr_seq: %0d bad of %0d reads, required 0 bad of 9", bad, acc_addr.size()); end
        n_checks++;
        if (proto_viol != 0) begin n_fail++; $display("FAIL basic_protocol: got %0d violations, required 0", proto_viol); end
    endtask

    task automatic test_waitrequest();
        int cyc, bad;
        load_basic_mem(); build_expected(); clear_records();
        ws_first = 5;
        run_load(0, cyc);
        n_checks++;
        if (cyc != 96) begin n_fail++; $display("FAIL wait_done_cycle: got %0d, required 96", cyc); end
        n_checks++;
        if (accepted != 9) begin n_fail++; $display("FAIL wait_accepted: got %0d, required 9", accepted); end
        n_checks++;
        if (proto_viol != 0) begin n_fail++; $display("FAIL wait_stable: got %0d violations, required 0", proto_viol); end
        bad = (got.size() != exp_q.size()) ? 1 : 0;
        foreach (exp_q[i]) if (i >= got.size() || got[i] != exp_q[i]) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL wait_data: %0d wrong of %0d writes, required 0", bad, got.size()); end
        n_checks++;
        if (acc_addr.size() == 0 || acc_addr[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL wait_first_addr: got %h, required 00000000", (acc_addr.size() > 0) ? acc_addr[0] : 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_backpressure();
        int cyc, bad;
        load_basic_mem(); build_expected(); clear_records();
        full3_trig = 4;
        run_load(0, cyc);
        n_checks++;
        if (cyc != 95) begin n_fail++; $display("FAIL bp_done_cycle: got %0d, required 95", cyc); end
        n_checks++;
        if (proto_viol != 0) begin n_fail++; $display("FAIL bp_write_while_full: got %0d violations, required 0", proto_viol); end
        n_checks++;
        if (cnt_fifo[3] != NB) begin n_fail++; $display("FAIL bp_row3_count: got %0d, required %0d", cnt_fifo[3], NB); end
        bad = (got.size() != exp_q.size()) ? 1 : 0;
        foreach (exp_q[i]) if (i >= got.size() || got[i] != exp_q[i]) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL bp_data: %0d wrong of %0d writes, required 0", bad, got.size()); end
    endtask

    task automatic test_start_while_busy();
        int cyc, bad;
        load_basic_mem(); build_expected(); clear_records();
        run_load(20, cyc);
        n_checks++;
        if (cyc != 91) begin n_fail++; $display("FAIL swb_done_cycle: got %0d, required 91", cyc); end
        n_checks++;
        if (done_cnt != 1 || accepted != 9) begin
            n_fail++;
            $display("FAIL swb_counts: done=%0d reads=%0d, required 1 and 9", done_cnt, accepted);
        end
        bad = (got.size() != exp_q.size()) ? 1 : 0;
        foreach (exp_q[i]) if (i >= got.size() || got[i] != exp_q[i]) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL swb_data: %0d wrong of %0d writes, required 0", bad, got.size()); end
    endtask

    task automatic test_spurious_valid();
        int cyc, bad;
        load_basic_mem(); build_expected(); clear_records();
        inject_now = 1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (got.size() != 0 || busy !== 1'b0 || avm_read !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_idle: writes=%0d busy=%b read=%b, required 0/0/0", got.size(), busy, avm_read);
        end
        inject_b_at = 3;
        run_load(0, cyc);
        n_checks++;
        if (cyc != 91 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL spur_done: cycle=%0d count=%0d, required 91 and 1", cyc, done_cnt);
        end
        bad = (got.size() != exp_q.size()) ? 1 : 0;
        foreach (exp_q[i]) if (i >= got.size() || got[i] != exp_q[i]) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL spur_data: %0d wrong of %0d writes, required 0", bad, got.size()); end
    endtask

    task automatic test_reset_mid_load();
        int  cyc, bad;
        bit  hit;
        load_basic_mem(); build_expected(); clear_records();
        hit = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cnt_fifo[5] >= 2) begin hit = 1; break; end
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL rst_reach_row5: got %0d row-5 writes, required 2", cnt_fifo[5]); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, avm_read, b_wrreq} !== 4'b0000 || a_wrreq !== '0 ||
            avm_address !== 32'd0 || a_data !== '0 || b_data !== '0) begin
            n_fail++;
            $display("FAIL rst_outputs: ctrl=%b a_wrreq=%h addr=%h a=%h b=%h, required all 0",
                     {busy, done, avm_read, b_wrreq}, a_wrreq, avm_address, a_data, b_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_records();
        inject_now = 1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (got.size() != 0 || busy !== 1'b0 || accepted != 0) begin
            n_fail++;
            $display("FAIL rst_late_valid: writes=%0d busy=%b reads=%0d, required 0/0/0", got.size(), busy, accepted);
        end
        run_load(0, cyc);
        n_checks++;
        if (acc_addr.size() == 0 || acc_addr[0] !== 32'd0 || cyc != 91) begin
            n_fail++;
            $display("FAIL rst_reload: first addr=%h cycle=%0d, required 00000000 and 91",
                     (acc_addr.size() > 0) ? acc_addr[0] : 32'hFFFF_FFFF, cyc);
        end
        bad = (got.size() != exp_q.size()) ? 1 : 0;
        foreach (exp_q[i]) if (i >= got.size() || got[i] != exp_q[i]) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL rst_reload_data: %0d wrong of %0d writes, required 0", bad, got.size()); end
    endtask

    task automatic test_random();
        int cyc, bad;
        rand_ws = 1; rand_lat = 1; rand_full = 1;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
            build_expected(); clear_records();
            run_load(0, cyc);
            bad = (got.size() != exp_q.size()) ? 1 : 0;
            foreach (exp_q[i]) if (i >= got.size() || got[i] != exp_q[i]) bad++;
            n_checks++;
            if (bad != 0) begin n_fail++; $display("FAIL rand_data[%0d]: %0d wrong of %0d writes, required 0", it, bad, got.size()); end
            n_checks++;
            if (proto_viol != 0 || accepted != 9 || done_cnt != 1) begin
                n_fail++;
                $display("FAIL rand_protocol[%0d]: viol=%0d reads=%0d done=%0d, required 0/9/1", it, proto_viol, accepted, done_cnt);
            end
        end
        rand_ws = 0; rand_lat = 0; rand_full = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        rst_n = 1'b0;
        start = 1'b0;
        test_reset();
        test_basic();
        test_waitrequest();
        test_backpressure();
        test_start_while_busy();
        test_spurious_valid();
        test_reset_mid_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
